// File: rtl/vga_tile_pkg.sv
// Shared types and widths for the tile draw controller and its VGA pixel port.
// Contents: colour/coordinate widths, cell-coordinate widths, FSM state and
// client-id enums, and the packed tile request payload.
package vga_tile_pkg;

  localparam int unsigned COLOR_DEPTH = 9;
  localparam int unsigned X_W         = 10;
  localparam int unsigned Y_W         = 9;
  localparam int unsigned COL_W       = 4;
  localparam int unsigned ROW_W       = 5;

  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } state_t;

  typedef enum logic {
    CLIENT0 = 1'b0,
    CLIENT1 = 1'b1
  } client_id_t;

  typedef struct packed {
    logic [COL_W-1:0]       col;
    logic [ROW_W-1:0]       row;
    logic [COLOR_DEPTH-1:0] color;
  } tile_req_t;

endpackage

// File: rtl/tile_draw_ctrl_if.sv
// Request handshake and pixel-write bundle of the tile draw controller.
// master: request clients and pixel sink (drives valid/fields, sees ready/pixels)
// slave : tile_draw_ctrl (drives ready, x, y, color, write, busy)
interface tile_draw_ctrl_if;
  import vga_tile_pkg::*;

  logic                   req0_valid;
  logic                   req0_ready;
  logic [COL_W-1:0]       req0_col;
  logic [ROW_W-1:0]       req0_row;
  logic [COLOR_DEPTH-1:0] req0_color;

  logic                   req1_valid;
  logic                   req1_ready;
  logic [COL_W-1:0]       req1_col;
  logic [ROW_W-1:0]       req1_row;
  logic [COLOR_DEPTH-1:0] req1_color;

  logic [X_W-1:0]         x;
  logic [Y_W-1:0]         y;
  logic [COLOR_DEPTH-1:0] color;
  logic                   write;
  logic                   busy;

  modport master (
    output req0_valid, req0_col, req0_row, req0_color,
    output req1_valid, req1_col, req1_row, req1_color,
    input  req0_ready, req1_ready,
    input  x, y, color, write, busy
  );

  modport slave (
    input  req0_valid, req0_col, req0_row, req0_color,
    input  req1_valid, req1_col, req1_row, req1_color,
    output req0_ready, req1_ready,
    output x, y, color, write, busy
  );

endinterface

// File: rtl/tile_rr_arbiter.sv
// Two-requester round-robin arbiter with a last-grant register.
// Ports:
//   clk_i, rst_ni : clock, synchronous active-low reset
//   en_i          : arbitration allowed this cycle
//   req_i[1:0]    : request per client
//   grant_o[1:0]  : one-hot combinational grant (zero when disabled or idle)
module tile_rr_arbiter
  import vga_tile_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] grant_o
);

  client_id_t last_q;

  // On a tie, favour the client that was not granted last.
  always_comb begin
    grant_o = 2'b00;
    if (en_i) begin
      case (req_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        2'b11:   grant_o = (last_q == CLIENT1) ? 2'b01 : 2'b10;
        default: grant_o = 2'b00;
      endcase
    end
  end

  // Reset to CLIENT1 so client 0 wins the first tie.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_q <= CLIENT1;
    end else if (grant_o != 2'b00) begin
      last_q <= grant_o[1] ? CLIENT1 : CLIENT0;
    end
  end

endmodule

// File: rtl/tile_draw_ctrl.sv
// Tile draw controller: accepts cell-draw requests from two clients and
// rasterises each TILE x TILE cell onto a VGA pixel-write port.
// Ports:
//   clock, resetn : 50 MHz clock, synchronous active-low reset
//   bus (slave)   : reqN_valid/ready/col/row/color handshakes, registered
//                   x/y/color/write pixel port, busy
// Optional feature: define TILE_DRAW_BORDER_EN to draw a one-pixel black
// border around every tile.
module tile_draw_ctrl
  import vga_tile_pkg::*;
#(
  parameter int unsigned TILE  = 16,
  parameter int unsigned NCOLS = 10,
  parameter int unsigned NROWS = 20,
  parameter int unsigned X0    = 240,
  parameter int unsigned Y0    = 80
) (
  input  logic         clock,
  input  logic         resetn,
  tile_draw_ctrl_if.slave bus
);

  localparam int unsigned D_W = (TILE > 1) ? $clog2(TILE) : 1;

  state_t                 state_q;
  tile_req_t              tile_q;
  logic [D_W-1:0]         dx_q, dy_q;
  logic [D_W-1:0]         dx_d, dy_d;
  logic [X_W-1:0]         x_q, x_d;
  logic [Y_W-1:0]         y_q, y_d;
  logic [COLOR_DEPTH-1:0] color_q, color_d;
  logic                   write_q;

  logic [1:0]             req_vld;
  logic [1:0]             grant;
  logic                   arb_en;
  logic                   xfer;
  logic                   in_range;
  logic                   last_px;
  tile_req_t              sel_req;
  tile_req_t              src_req;

  assign req_vld = {bus.req1_valid, bus.req0_valid};
  // No grants while in reset so nothing is consumed that will be forgotten.
  assign arb_en  = (state_q == IDLE) && resetn;

  tile_rr_arbiter u_arb (
    .clk_i   (clock),
    .rst_ni  (resetn),
    .en_i    (arb_en),
    .req_i   (req_vld),
    .grant_o (grant)
  );

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];
  assign xfer           = |(grant & req_vld);

  // Payload of the granted client.
  always_comb begin
    if (grant[1]) begin
      sel_req.col   = bus.req1_col;
      sel_req.row   = bus.req1_row;
      sel_req.color = bus.req1_color;
    end else begin
      sel_req.col   = bus.req0_col;
      sel_req.row   = bus.req0_row;
      sel_req.color = bus.req0_color;
    end
  end

  assign in_range = (32'(sel_req.col) < NCOLS) && (32'(sel_req.row) < NROWS);
  assign last_px  = (dx_q == D_W'(TILE - 1)) && (dy_q == D_W'(TILE - 1));

  // Next pixel: first pixel of the incoming tile in IDLE, raster step in DRAW.
  always_comb begin
    src_req = tile_q;
    dx_d    = '0;
    dy_d    = '0;
    if (state_q == IDLE) begin
      src_req = sel_req;
    end else if (dx_q == D_W'(TILE - 1)) begin
      dy_d = dy_q + D_W'(1);
    end else begin
      dx_d = dx_q + D_W'(1);
      dy_d = dy_q;
    end
    x_d = X_W'(X0 + 32'(src_req.col) * TILE + 32'(dx_d));
    y_d = Y_W'(Y0 + 32'(src_req.row) * TILE + 32'(dy_d));
  end

`ifdef TILE_DRAW_BORDER_EN
  logic on_border;

  // Edge pixels of the tile are forced to black.
  always_comb begin
    on_border = (dx_d == '0) || (dx_d == D_W'(TILE - 1)) ||
                (dy_d == '0) || (dy_d == D_W'(TILE - 1));
    color_d   = on_border ? '0 : src_req.color;
  end
`else
  assign color_d = src_req.color;
`endif

  // Controller FSM with registered pixel port.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= IDLE;
      tile_q  <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      color_q <= '0;
      write_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (xfer) begin
            tile_q <= sel_req;
            dx_q   <= '0;
            dy_q   <= '0;
            // Out-of-range cells are consumed without drawing.
            if (in_range) begin
              state_q <= DRAW;
              write_q <= 1'b1;
              x_q     <= x_d;
              y_q     <= y_d;
              color_q <= color_d;
            end
          end
        end
        DRAW: begin
          if (last_px) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            dx_q    <= '0;
            dy_q    <= '0;
          end else begin
            write_q <= 1'b1;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            x_q     <= x_d;
            y_q     <= y_d;
            color_q <= color_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.x     = x_q;
  assign bus.y     = y_q;
  assign bus.color = color_q;
  assign bus.write = write_q;
  assign bus.busy  = (state_q == DRAW);

endmodule

// File: tb/tb_tile_draw_ctrl.sv
// Directed self-checking bench for tile_draw_ctrl (default parameters).
module tb_tile_draw_ctrl;
  import vga_tile_pkg::*;

  localparam int TILE = 16;
  localparam int X0   = 240;
  localparam int Y0   = 80;
  localparam int NPIX = TILE * TILE;

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  always #5 clk = ~clk;

  tile_draw_ctrl_if bus ();

  tile_draw_ctrl #(
    .TILE  (16),
    .NCOLS (10),
    .NROWS (20),
    .X0    (240),
    .Y0    (80)
  ) dut (
    .clock  (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  int wq_x[$];
  int wq_y[$];
  int wq_c[$];
  int wq_cyc[$];
  int gq_id[$];
  int gq_cyc[$];
  int both_rdy = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record pixel writes and handshake transfers mid-cycle.
  always @(negedge clk) begin
    if (bus.write === 1'b1) begin
      wq_x.push_back(int'(bus.x));
      wq_y.push_back(int'(bus.y));
      wq_c.push_back(int'(bus.color));
      wq_cyc.push_back(cyc);
    end
    if (bus.req0_valid === 1'b1 && bus.req0_ready === 1'b1) begin
      gq_id.push_back(0);
      gq_cyc.push_back(cyc);
    end
    if (bus.req1_valid === 1'b1 && bus.req1_ready === 1'b1) begin
      gq_id.push_back(1);
      gq_cyc.push_back(cyc);
    end
    if (bus.req0_ready === 1'b1 && bus.req1_ready === 1'b1) both_rdy++;
  end

  function automatic int exp_color(int dx, int dy, int c);
`ifdef TILE_DRAW_BORDER_EN
    if (dx == 0 || dx == TILE - 1 || dy == 0 || dy == TILE - 1) return 0;
`endif
    return c;
  endfunction

  // Number of pixels of one tile that deviate from the expected raster.
  function automatic int tile_errs(int base, int col, int row, int c, int t0);
    int errs = 0;
    for (int i = 0; i < NPIX; i++) begin
      int dx = i % TILE;
      int dy = i / TILE;
      if (base + i >= wq_x.size()) begin
        errs++;
      end else begin
        if (wq_x[base + i] != X0 + col * TILE + dx) errs++;
        if (wq_y[base + i] != Y0 + row * TILE + dy) errs++;
        if (wq_c[base + i] != exp_color(dx, dy, c)) errs++;
        if (wq_cyc[base + i] != t0 + 1 + i) errs++;
      end
    end
    return errs;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req0_valid = 1'b0;
    bus.req0_col   = '0;
    bus.req0_row   = '0;
    bus.req0_color = '0;
    bus.req1_valid = 1'b0;
    bus.req1_col   = '0;
    bus.req1_row   = '0;
    bus.req1_color = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    resetn = 1'b0;
    repeat (2) tick();
    resetn = 1'b1;
    wq_x.delete();
    wq_y.delete();
    wq_c.delete();
    wq_cyc.delete();
    gq_id.delete();
    gq_cyc.delete();
    both_rdy = 0;
  endtask

  // Each client keeps valid high until its n tiles have transferred; returns
  // at the first cycle with nothing pending and the controller idle.
  task automatic run_reqs(input int n0, input int c0, input int r0, input int k0,
                          input int n1, input int c1, input int r1, input int k1,
                          input int budget, output bit timed_out, output int exit_cyc);
    int d0 = 0;
    int d1 = 0;
    int t  = 0;
    timed_out = 1'b1;
    exit_cyc  = -1;
    while (t < budget) begin
      bus.req0_valid = (d0 < n0);
      bus.req0_col   = 4'(c0);
      bus.req0_row   = 5'(r0);
      bus.req0_color = 9'(k0);
      bus.req1_valid = (d1 < n1);
      bus.req1_col   = 4'(c1);
      bus.req1_row   = 5'(r1);
      bus.req1_color = 9'(k1);
      #1;
      if (!bus.req0_valid && !bus.req1_valid && bus.busy === 1'b0) begin
        timed_out = 1'b0;
        exit_cyc  = cyc;
        break;
      end
      if (bus.req0_valid && bus.req0_ready === 1'b1) d0++;
      if (bus.req1_valid && bus.req1_ready === 1'b1) d1++;
      tick();
      t++;
    end
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    resetn = 1'b0;
    repeat (2) tick();
    n_cmp++; if (bus.write !== 1'b0) begin n_fail++; $display("FAIL reset_write got %b want 0", bus.write); end
    n_cmp++; if (bus.x !== 10'd0) begin n_fail++; $display("FAIL reset_x got %0d want 0", bus.x); end
    n_cmp++; if (bus.y !== 9'd0) begin n_fail++; $display("FAIL reset_y got %0d want 0", bus.y); end
    n_cmp++; if (bus.color !== 9'd0) begin n_fail++; $display("FAIL reset_color got %0h want 0", bus.color); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    resetn = 1'b1;
    tick();
    n_cmp++; if (bus.busy !== 1'b0 || bus.write !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset busy=%b write=%b want 0/0", bus.busy, bus.write); end
  endtask

  task automatic test_single_tile();
    bit to;
    int ex;
    int t0;
    do_reset();
    run_reqs(1, 0, 0, 'h1C0, 0, 0, 0, 0, 600, to, ex);
    n_cmp++; if (to) begin n_fail++; $display("FAIL single_timeout got timeout want completion"); end
    t0 = (gq_cyc.size() > 0) ? gq_cyc[0] : -1000;
    n_cmp++; if (gq_id.size() != 1 || (gq_id.size() > 0 && gq_id[0] != 0)) begin n_fail++; $display("FAIL single_grant got %0d grants want one to client 0", gq_id.size()); end
    n_cmp++; if (wq_x.size() != NPIX) begin n_fail++; $display("FAIL single_count got %0d writes want %0d", wq_x.size(), NPIX); end
    n_cmp++; if (wq_x.size() == 0 || wq_x[0] != 240 || wq_y[0] != 80 || wq_cyc[0] != t0 + 1) begin n_fail++; $display("FAIL single_first got (%0d,%0d)@%0d want (240,80)@%0d", (wq_x.size() > 0) ? wq_x[0] : -1, (wq_y.size() > 0) ? wq_y[0] : -1, (wq_cyc.size() > 0) ? wq_cyc[0] : -1, t0 + 1); end
    n_cmp++; if (wq_x.size() < NPIX || wq_x[NPIX-1] != 255 || wq_y[NPIX-1] != 95 || wq_cyc[NPIX-1] != t0 + 256) begin n_fail++; $display("FAIL single_last got %0d writes, want last (255,95)@%0d", wq_x.size(), t0 + 256); end
    n_cmp++; if (tile_errs(0, 0, 0, 'h1C0, t0) != 0) begin n_fail++; $display("FAIL single_raster got %0d pixel errors want 0", tile_errs(0, 0, 0, 'h1C0, t0)); end
    n_cmp++; if (ex != t0 + 257) begin n_fail++; $display("FAIL single_busy_fall got cycle %0d want %0d", ex, t0 + 257); end
    n_cmp++; if (bus.write !== 1'b0 || bus.x !== 10'd255 || bus.y !== 9'd95) begin n_fail++; $display("FAIL single_hold got write=%b (%0d,%0d) want 0 (255,95)", bus.write, bus.x, bus.y); end
  endtask

  task automatic test_contention();
    bit to;
    int ex;
    int t0;
    int t1;
    do_reset();
    run_reqs(1, 1, 2, 'h00F, 1, 3, 4, 'h1F0, 1000, to, ex);
    n_cmp++; if (to) begin n_fail++; $display("FAIL contend_timeout got timeout want completion"); end
    n_cmp++; if (gq_id.size() != 2 || gq_id[0] != 0 || gq_id[1] != 1) begin n_fail++; $display("FAIL contend_order got %0d grants want order 0,1", gq_id.size()); end
    t0 = (gq_cyc.size() > 0) ? gq_cyc[0] : -1000;
    t1 = (gq_cyc.size() > 1) ? gq_cyc[1] : -1000;
    n_cmp++; if (t1 != t0 + 257) begin n_fail++; $display("FAIL contend_gap got %0d want %0d", t1 - t0, 257); end
    n_cmp++; if (wq_x.size() != 2 * NPIX || wq_cyc[NPIX-1] != t1 - 1) begin n_fail++; $display("FAIL contend_idle_gap got %0d writes want %0d with 256th write just before grant 1", wq_x.size(), 2 * NPIX); end
    n_cmp++; if (wq_x.size() <= NPIX || wq_x[NPIX] != 288 || wq_y[NPIX] != 144) begin n_fail++; $display("FAIL contend_req1_first got (%0d,%0d) want (288,144)", (wq_x.size() > NPIX) ? wq_x[NPIX] : -1, (wq_y.size() > NPIX) ? wq_y[NPIX] : -1); end
    n_cmp++; if (tile_errs(0, 1, 2, 'h00F, t0) + tile_errs(NPIX, 3, 4, 'h1F0, t1) != 0) begin n_fail++; $display("FAIL contend_raster got %0d pixel errors want 0", tile_errs(0, 1, 2, 'h00F, t0) + tile_errs(NPIX, 3, 4, 'h1F0, t1)); end
    n_cmp++; if (both_rdy != 0) begin n_fail++; $display("FAIL contend_onehot got %0d double-ready cycles want 0", both_rdy); end
  endtask

  task automatic test_out_of_range();
    bit to;
    int ex;
    int t_oor = -1;
    logic rdy0_next;
    logic busy_next;
    logic wr_next;
    do_reset();
    bus.req1_valid = 1'b1;
    bus.req1_col   = 4'd10;
    bus.req1_row   = 5'd0;
    bus.req1_color = 9'h155;
    #1;
    for (int k = 0; k < 10; k++) begin
      if (bus.req1_ready === 1'b1) begin
        t_oor = cyc;
        break;
      end
      tick();
    end
    tick();
    bus.req1_valid = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_col   = 4'd4;
    bus.req0_row   = 5'd5;
    bus.req0_color = 9'h0AA;
    #1;
    rdy0_next = bus.req0_ready;
    busy_next = bus.busy;
    wr_next   = bus.write;
    run_reqs(1, 4, 5, 'h0AA, 0, 0, 0, 0, 600, to, ex);
    n_cmp++; if (t_oor < 0) begin n_fail++; $display("FAIL oor_ready got no req1_ready want one pulse"); end
    n_cmp++; if (busy_next !== 1'b0 || wr_next !== 1'b0) begin n_fail++; $display("FAIL oor_no_draw got busy=%b write=%b want 0/0", busy_next, wr_next); end
    n_cmp++; if (rdy0_next !== 1'b1) begin n_fail++; $display("FAIL oor_next_grant got ready0=%b want 1", rdy0_next); end
    n_cmp++; if (gq_id.size() != 2 || gq_id[0] != 1 || gq_id[1] != 0 || gq_cyc[1] != gq_cyc[0] + 1) begin n_fail++; $display("FAIL oor_grants got %0d grants want req1 then req0 next cycle", gq_id.size()); end
    n_cmp++; if (to || wq_x.size() != NPIX || wq_x[0] != 304 || wq_y[0] != 160 || wq_cyc[0] != t_oor + 2) begin n_fail++; $display("FAIL oor_follow got %0d writes want %0d starting (304,160)@%0d", wq_x.size(), NPIX, t_oor + 2); end
  endtask

  task automatic test_reset_mid();
    int cnt = 0;
    bit got = 1'b0;
    do_reset();
    bus.req0_valid = 1'b1;
    bus.req0_col   = 4'd2;
    bus.req0_row   = 5'd3;
    bus.req0_color = 9'h155;
    #1;
    for (int k = 0; k < 10; k++) begin
      if (bus.req0_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    tick();
    bus.req0_valid = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (bus.write === 1'b1) cnt++;
      if (cnt == 100) break;
      tick();
    end
    n_cmp++; if (!got || cnt != 100) begin n_fail++; $display("FAIL midrst_setup got grant=%b writes=%0d want 1/100", got, cnt); end
    resetn = 1'b0;
    tick();
    n_cmp++; if (bus.write !== 1'b0 || bus.x !== 10'd0 || bus.y !== 9'd0 || bus.color !== 9'd0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_clear got write=%b x=%0d y=%0d c=%0h busy=%b want all 0", bus.write, bus.x, bus.y, bus.color, bus.busy); end
    resetn = 1'b1;
    repeat (300) tick();
    n_cmp++; if (wq_x.size() != 100 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_no_replay got %0d writes busy=%b want 100/0", wq_x.size(), bus.busy); end
  endtask

  task automatic test_corner_tile();
    bit to;
    int ex;
    int nz = 0;
    int nc = 0;
    int t0;
    int exp_nz;
    do_reset();
    run_reqs(1, 9, 19, 'h03F, 0, 0, 0, 0, 600, to, ex);
    t0 = (gq_cyc.size() > 0) ? gq_cyc[0] : -1000;
    foreach (wq_c[i]) begin
      if (wq_c[i] == 0) nz++;
      if (wq_c[i] == 'h03F) nc++;
    end
`ifdef TILE_DRAW_BORDER_EN
    exp_nz = 60;
`else
    exp_nz = 0;
`endif
    n_cmp++; if (to || nz != exp_nz || nc != NPIX - exp_nz) begin n_fail++; $display("FAIL corner_colors got zero=%0d fill=%0d want %0d/%0d", nz, nc, exp_nz, NPIX - exp_nz); end
    n_cmp++; if (wq_x.size() != NPIX || wq_x[NPIX-1] != 399 || wq_y[NPIX-1] != 399 || wq_c[NPIX-1] != exp_color(15, 15, 'h03F)) begin n_fail++; $display("FAIL corner_last got %0d writes want last (399,399) color %0h", wq_x.size(), exp_color(15, 15, 'h03F)); end
    n_cmp++; if (tile_errs(0, 9, 19, 'h03F, t0) != 0) begin n_fail++; $display("FAIL corner_raster got %0d pixel errors want 0", tile_errs(0, 9, 19, 'h03F, t0)); end
  endtask

  task automatic test_fairness();
    bit to;
    int ex;
    int bad = 0;
    do_reset();
    run_reqs(3, 0, 0, 'h111, 3, 9, 0, 'h022, 2000, to, ex);
    for (int i = 0; i < gq_id.size(); i++) begin
      if (gq_id[i] != i % 2) bad++;
      if (i > 0 && gq_cyc[i] != gq_cyc[i-1] + 257) bad++;
    end
    n_cmp++; if (to || gq_id.size() != 6 || bad != 0) begin n_fail++; $display("FAIL fairness got %0d grants %0d order/spacing errors want 6 alternating", gq_id.size(), bad); end
    n_cmp++; if (wq_x.size() != 6 * NPIX) begin n_fail++; $display("FAIL fairness_count got %0d writes want %0d", wq_x.size(), 6 * NPIX); end
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_contention();
    test_out_of_range();
    test_reset_mid();
    test_corner_tile();
    test_fairness();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
